msb_scan_encoder: RTL and testbench

- Streaming successor to the single-cycle registered MSB encoder.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the index of every set bit, one per beat, in priority order (MSB-first by default), over a second valid/ready handshake.
- Used wherever request vectors must be serviced one bit at a time: interrupt, grant or dirty-line enumeration.

---
 rtl/msb_scan_encoder.sv | 140 ++++++++++++++
 tb/tb_msb_scan_encoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msb_scan_encoder.sv
// msb_scan_encoder
//   Streaming set-bit enumerator. A WIDTH-bit word is accepted over an
//   input valid/ready handshake. The index of each of its set bits is then
//   emitted, one per beat, over an output valid/ready handshake. Indices come
//   highest-first by default, or lowest-first when LSB_FIRST = 1. An all-zero
//   word produces a single beat flagged with out_zero.
//
//   Optional build macro: MSB_SCAN_COUNT_EN adds out_count, the population
//   count of the loaded word, held for all beats of that word.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   data_in holds a word to load
//   in_ready   block is idle and can accept a word
//   data_in    word to scan (sampled only on the accept edge)
//   out_valid  out_index / out_last / out_zero are valid
//   out_ready  consumer accepts the current beat
//   out_index  index of the current priority set bit
//   out_last   current beat is the final beat of this word
//   out_zero   loaded word was all zeros (single beat, index 0)
//   busy       block is not idle
//   out_count  (MSB_SCAN_COUNT_EN only) set-bit count of the loaded word
module msb_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    localparam int IDXW     = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_index,
    output logic             out_last,
    output logic             out_zero,
    output logic             busy
`ifdef MSB_SCAN_COUNT_EN
    ,
    output logic [IDXW:0]    out_count
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] ZERO = 2'd2;

    localparam int CW = IDXW + 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] shadow;
    logic             one_left;

    // Priority pick over the remaining bits. The loop order makes the last
    // hit win, so the scan direction selects highest- or lowest-first.
    function automatic logic [IDXW-1:0] pick(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        if (LSB_FIRST != 1'b0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) r = IDXW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) r = IDXW'(i);
            end
        end
        return r;
    endfunction

`ifdef MSB_SCAN_COUNT_EN
    function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction
`endif

    // Exactly one bit still set: clearing the lowest set bit leaves nothing.
    assign one_left = (shadow != '0) &&
                      ((shadow & (shadow - WIDTH'(1))) == '0);

    // Outputs are decoded purely from registered state and shadow.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state != IDLE);
        out_zero  = (state == ZERO);
        out_index = '0;
        out_last  = 1'b0;
        if (state == SCAN) begin
            out_index = pick(shadow);
            out_last  = one_left;
        end else if (state == ZERO) begin
            out_last  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shadow <= data_in;
                        state  <= (data_in != '0) ? SCAN : ZERO;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        shadow <= shadow & ~(WIDTH'(1) << out_index);
                        if (one_left) state <= IDLE;
                    end
                end
                ZERO: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MSB_SCAN_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_count <= '0;
        end else if (state == IDLE && in_valid) begin
            out_count <= popcnt(data_in);
        end
    end
`endif

endmodule

// File: tb/tb_msb_scan_encoder.sv
module tb_msb_scan_encoder;

    logic        clock;
    logic        reset;
    logic        iv   [3];
    logic        ordy [3];
    logic [11:0] din  [3];

    logic        ov [3];
    logic        ir [3];
    logic        ol [3];
    logic        oz [3];
    logic        bz [3];
    logic [3:0]  oi [3];
    logic [2:0]  oi0, oi1;
    logic [3:0]  oi2;
`ifdef MSB_SCAN_COUNT_EN
    logic [3:0]  oc0, oc1;
    logic [4:0]  oc2;
    int          oc [3];
    assign oc[0] = int'(oc0);
    assign oc[1] = int'(oc1);
    assign oc[2] = int'(oc2);
`endif

    assign oi[0] = {1'b0, oi0};
    assign oi[1] = {1'b0, oi1};
    assign oi[2] = oi2;

    // Instance 0: WIDTH 8, highest-first. Instance 1: WIDTH 8, lowest-first.
    // Instance 2: WIDTH 12, highest-first.
    msb_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb8 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .data_in(din[0][7:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_index(oi0), .out_last(ol[0]), .out_zero(oz[0]), .busy(bz[0])
`ifdef MSB_SCAN_COUNT_EN
        , .out_count(oc0)
`endif
    );

    msb_scan_encoder #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb8 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .data_in(din[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_index(oi1), .out_last(ol[1]), .out_zero(oz[1]), .busy(bz[1])
`ifdef MSB_SCAN_COUNT_EN
        , .out_count(oc1)
`endif
    );

    msb_scan_encoder #(.WIDTH(12), .LSB_FIRST(1'b0)) u_w12 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .data_in(din[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_index(oi2), .out_last(ol[2]), .out_zero(oz[2]), .busy(bz[2])
`ifdef MSB_SCAN_COUNT_EN
        , .out_count(oc2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic int wof(input int k);
        return (k == 2) ? 12 : 8;
    endfunction

    // Reference model: on acceptance the word is turned into the ordered list
    // of set-bit indices; each consumed beat advances through that list.
    int mlist [3][16];
    int mn    [3];
    int mpos  [3];
    bit mz    [3];
    int mcnt  [3];

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mn[k] = 0; mpos[k] = 0; mz[k] = 0; mcnt[k] = 0;
            end else begin
                if ((mpos[k] < mn[k]) || mz[k]) begin
                    if (ordy[k]) begin
                        if (mz[k]) mz[k] = 0;
                        else mpos[k]++;
                    end
                end else if (iv[k]) begin
                    mn[k] = 0; mpos[k] = 0;
                    if (k == 1) begin
                        for (int i = 0; i < wof(k); i++)
                            if (din[k][i]) begin mlist[k][mn[k]] = i; mn[k]++; end
                    end else begin
                        for (int i = wof(k) - 1; i >= 0; i--)
                            if (din[k][i]) begin mlist[k][mn[k]] = i; mn[k]++; end
                    end
                    mz[k]   = (mn[k] == 0);
                    mcnt[k] = mn[k];
                end
            end
        end
    end

    // Beat log of accepted beats, used for the literal expectations.
    int blog [3][4096];
    int bn   [3] = '{0, 0, 0};

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            bit act;
            act = (mpos[k] < mn[k]) || mz[k];
            chk("out_valid", k, int'(ov[k]), int'(act));
            chk("in_ready", k, int'(ir[k]), int'(!act));
            chk("busy", k, int'(bz[k]), int'(act));
            chk("out_zero", k, int'(oz[k]), int'(mz[k]));
            if (act) begin
                chk("out_index", k, int'(oi[k]), mz[k] ? 0 : mlist[k][mpos[k]]);
                chk("out_last", k, int'(ol[k]), int'(mz[k] || (mpos[k] == mn[k] - 1)));
`ifdef MSB_SCAN_COUNT_EN
                chk("out_count", k, oc[k], mcnt[k]);
`endif
            end
            if (reset) begin
                chk("rst_index", k, int'(oi[k]), 0);
                chk("rst_last", k, int'(ol[k]), 0);
`ifdef MSB_SCAN_COUNT_EN
                chk("rst_count", k, oc[k], 0);
`endif
            end
            if (!reset && ov[k] && ordy[k] && bn[k] < 4096) begin
                blog[k][bn[k]] = int'(oi[k]);
                bn[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic load8(input logic [7:0] w);
        iv[0] = 1'b1; iv[1] = 1'b1;
        din[0] = {4'h0, w}; din[1] = {4'h0, w};
        tick();
        iv[0] = 1'b0; iv[1] = 1'b0;
    endtask

    initial begin
        int s0, s1, s2, c;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; din[k] = '0;
        end
        #1;
        chk("lit_rst_in_ready", 0, int'(ir[0]), 1);
        chk("lit_rst_valid", 0, int'(ov[0]), 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // 8'b1010_0100, consumer always ready
        s0 = bn[0]; s1 = bn[1];
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        load8(8'hA4);
        for (int i = 0; i < 4; i++) tick();
        chk("lit_a4_beats", 0, bn[0] - s0, 3);
        chk("lit_a4_b0", 0, blog[0][s0], 7);
        chk("lit_a4_b1", 0, blog[0][s0 + 1], 5);
        chk("lit_a4_b2", 0, blog[0][s0 + 2], 2);
        chk("lit_a4_lsb_b0", 1, blog[1][s1], 2);
        chk("lit_a4_lsb_b1", 1, blog[1][s1 + 1], 5);
        chk("lit_a4_lsb_b2", 1, blog[1][s1 + 2], 7);
        chk("lit_a4_ready", 0, int'(ir[0]), 1);

        // zero word
        s0 = bn[0];
        load8(8'h00);
        chk("lit_zero_flag", 0, int'(oz[0]), 1);
        chk("lit_zero_last", 0, int'(ol[0]), 1);
`ifdef MSB_SCAN_COUNT_EN
        chk("lit_zero_count", 0, oc[0], 0);
`endif
        tick(); tick();
        chk("lit_zero_beats", 0, bn[0] - s0, 1);
        chk("lit_zero_idx", 0, blog[0][s0], 0);

        // 8'hFF under backpressure
        s0 = bn[0]; s1 = bn[1];
        load8(8'hFF);
`ifdef MSB_SCAN_COUNT_EN
        chk("lit_ff_count", 0, oc[0], 8);
`endif
        c = 0;
        while ((bn[0] - s0) < 8 && c < 60) begin
            ordy[0] = (c % 3 == 0); ordy[1] = ordy[0];
            tick();
            c++;
        end
        chk("lit_ff_done", 0, int'(c < 60), 1);
        for (int i = 0; i < 8; i++) begin
            chk("lit_ff_msb", 0, blog[0][s0 + i], 7 - i);
            chk("lit_ff_lsb", 1, blog[1][s1 + i], i);
        end
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        tick(); tick();
        chk("lit_ff_beats", 0, bn[0] - s0, 8);

        // reset after first beat of 8'b0110_0000
        s0 = bn[0];
        load8(8'h60);
        c = 0;
        while (bn[0] == s0 && c < 10) begin tick(); c++; end
        chk("lit_mid_first", 0, int'(bn[0] > s0), 1);
        reset = 1'b1;
        #1;
        chk("lit_mid_valid", 0, int'(ov[0]), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("lit_mid_ready", 0, int'(ir[0]), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("lit_mid_beats", 0, bn[0] - s0, 1);
        chk("lit_mid_b0", 0, blog[0][s0], 6);

        // WIDTH 12: 12'h801 with an in_valid pulse while scanning
        s2 = bn[2];
        ordy[2] = 1'b1;
        iv[2] = 1'b1; din[2] = 12'h801;
        tick();
        din[2] = 12'hFFF;
        tick();
        iv[2] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("lit_w12_beats", 2, bn[2] - s2, 2);
        chk("lit_w12_b0", 2, blog[2][s2], 11);
        chk("lit_w12_b1", 2, blog[2][s2 + 1], 0);

        // randomized traffic on all instances
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 3; k++) begin
                iv[k]   = ($urandom_range(2) == 0);
                din[k]  = ($urandom_range(7) == 0) ? 12'h000 : 12'($urandom);
                ordy[k] = ($urandom_range(3) != 0);
            end
            if ($urandom_range(199) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end
        for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; ordy[k] = 1'b1; end
        for (int i = 0; i < 20; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
